// File: rtl/qu_mem_arbiter.sv
// qu_mem_arbiter
// Shares one single-port, byte-writable 32-bit RAM between instruction fetch
// and load/store. Load/store has priority. A streak counter bounds how long a
// waiting fetch can be starved. Read responses are routed back one cycle later
// using a 2-bit tag that records who owned the RAM in the previous cycle.
module qu_mem_arbiter #(
    parameter int ADDR_WIDTH    = 12,
    parameter int MAX_LS_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    // fetch requester
    input  logic                  if_req,
    input  logic [31:0]           if_addr,
    output logic                  if_gnt,
    output logic                  if_rsp_valid,
    output logic [31:0]           if_rsp_data,
    // load/store requester
    input  logic                  ls_req,
    input  logic [3:0]            ls_wr_en,
    input  logic [31:0]           ls_addr,
    input  logic [31:0]           ls_wdata,
    output logic                  ls_gnt,
    output logic                  ls_rsp_valid,
    output logic [31:0]           ls_rsp_data,
    // pipeline flush
    input  logic                  flush,
    // RAM port
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [31:0]           mem_din,
    input  logic [31:0]           mem_dout
);

    localparam int SW = (MAX_LS_STREAK < 1) ? 1 : $clog2(MAX_LS_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_STREAK);

    typedef enum logic [1:0] {
        TAG_NONE  = 2'd0,
        TAG_IF    = 2'd1,
        TAG_LS_RD = 2'd2,
        TAG_LS_WR = 2'd3
    } tag_t;

    tag_t          tag, tag_nxt;
    logic [SW-1:0] streak, streak_nxt;

    // Address bits below word granularity and above the RAM size are dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_WIDTH+2], if_addr[1:0],
                                ls_addr[31:ADDR_WIDTH+2], ls_addr[1:0]};

    // Grant selection: flush blocks fetch, a saturated streak forces fetch,
    // otherwise load/store wins. Everything is forced low while in reset.
    always_comb begin
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        if (!rst) begin
            if (flush) begin
                ls_gnt = ls_req;
            end else if (if_req && (streak == STREAK_MAX)) begin
                if_gnt = 1'b1;
            end else if (ls_req) begin
                ls_gnt = 1'b1;
            end else begin
                if_gnt = if_req;
            end
        end
    end

    // RAM drive follows the winner; idle cycles present an all-zero port.
    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 4'b0000;
        mem_addr = '0;
        mem_din  = 32'h0;
        if (if_gnt) begin
            mem_en   = 1'b1;
            mem_addr = if_addr[ADDR_WIDTH+1:2];
        end else if (ls_gnt) begin
            mem_en   = 1'b1;
            mem_we   = ls_wr_en;
            mem_addr = ls_addr[ADDR_WIDTH+1:2];
            mem_din  = ls_wdata;
        end
    end

    // Streak bookkeeping: count LS wins while fetch waits, clear whenever
    // fetch is served or stops asking; flush-only cycles leave it alone.
    always_comb begin
        streak_nxt = streak;
        if (!if_req || if_gnt) begin
            streak_nxt = '0;
        end else if (ls_gnt && (streak != STREAK_MAX)) begin
            streak_nxt = streak + 1'b1;
        end
    end

    // Tag for next cycle's response, reloaded every cycle from the grant.
    always_comb begin
        tag_nxt = TAG_NONE;
        if (if_gnt) begin
            tag_nxt = TAG_IF;
        end else if (ls_gnt) begin
            tag_nxt = (ls_wr_en != 4'b0000) ? TAG_LS_WR : TAG_LS_RD;
        end
    end

    // State registers; reset discards any response still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag    <= TAG_NONE;
            streak <= '0;
        end else begin
            tag    <= tag_nxt;
            streak <= streak_nxt;
        end
    end

    // Response routing; a flush kills a fetch response presenting this cycle.
    always_comb begin
        if_rsp_valid = 1'b0;
        if_rsp_data  = 32'h0;
        ls_rsp_valid = 1'b0;
        ls_rsp_data  = 32'h0;
        case (tag)
            TAG_IF: begin
                if (!flush) begin
                    if_rsp_valid = 1'b1;
                    if_rsp_data  = mem_dout;
                end
            end
            TAG_LS_RD: begin
                ls_rsp_valid = 1'b1;
                ls_rsp_data  = mem_dout;
            end
            TAG_LS_WR: begin
                ls_rsp_valid = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_qu_mem_arbiter.sv
// Directed bench for qu_mem_arbiter with a behavioral byte-write RAM.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_qu_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        ls_req;
    logic [3:0]  ls_wr_en;
    logic [31:0] ls_addr, ls_wdata;
    logic        ls_gnt, ls_rsp_valid;
    logic [31:0] ls_rsp_data;
    logic        flush;
    logic [11:0] mem_addr;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    int checks = 0;
    int errors = 0;

    logic [31:0] ram [0:4095];

    always #5 clk = ~clk;

    qu_mem_arbiter #(.ADDR_WIDTH(12), .MAX_LS_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .ls_req(ls_req), .ls_wr_en(ls_wr_en), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
        .flush(flush),
        .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // Single-port RAM, read-before-write, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            mem_dout <= ram[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic drv(input logic ir, input logic [31:0] ia,
                       input logic lr, input logic [3:0] we,
                       input logic [31:0] la, input logic [31:0] wd);
        if_req = ir; if_addr = ia;
        ls_req = lr; ls_wr_en = we; ls_addr = la; ls_wdata = wd;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 32'h0;
        ram[4]  = 32'hDEADBEEF;
        ram[8]  = 32'hAABBCCDD;
        ram[12] = 32'h11112222;
        mem_dout = 32'h0;
        rst = 1'b1; flush = 1'b0;
        if_req = 0; if_addr = 0; ls_req = 0; ls_wr_en = 0; ls_addr = 0; ls_wdata = 0;

        // Reset: requests present but everything gated
        cyc(); drv(1, 32'h10, 1, 4'hF, 32'h20, 32'hFFFFFFFF);
        chk("rst_if_gnt", 32'(if_gnt), 0);
        chk("rst_ls_gnt", 32'(ls_gnt), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_din", mem_din, 0);
        chk("rst_if_rsp_v", 32'(if_rsp_valid), 0);
        chk("rst_ls_rsp_v", 32'(ls_rsp_valid), 0);

        cyc(); rst = 1'b0; drv(0, 0, 0, 0, 0, 0);
        chk("post_rst_if_v", 32'(if_rsp_valid), 0);
        chk("post_rst_ls_v", 32'(ls_rsp_valid), 0);

        // Fetch alone
        cyc(); drv(1, 32'h10, 0, 0, 0, 0);
        chk("f_if_gnt", 32'(if_gnt), 1);
        chk("f_ls_gnt", 32'(ls_gnt), 0);
        chk("f_mem_en", 32'(mem_en), 1);
        chk("f_mem_addr", 32'(mem_addr), 4);
        chk("f_mem_we", 32'(mem_we), 0);
        cyc(); drv(0, 0, 0, 0, 0, 0);
        chk("f_rsp_v", 32'(if_rsp_valid), 1);
        chk("f_rsp_d", if_rsp_data, 32'hDEADBEEF);
        chk("f_ls_v", 32'(ls_rsp_valid), 0);
        chk("f_ls_d", ls_rsp_data, 0);

        // Store vs fetch contention
        cyc(); drv(1, 32'h10, 1, 4'b0011, 32'h20, 32'h12345678);
        chk("st_ls_gnt", 32'(ls_gnt), 1);
        chk("st_if_gnt", 32'(if_gnt), 0);
        chk("st_mem_we", 32'(mem_we), 3);
        chk("st_mem_addr", 32'(mem_addr), 8);
        chk("st_mem_din", mem_din, 32'h12345678);
        cyc(); drv(1, 32'h10, 1, 0, 32'h20, 0);
        chk("st_ack_v", 32'(ls_rsp_valid), 1);
        chk("st_ack_d", ls_rsp_data, 0);
        chk("st_if_v", 32'(if_rsp_valid), 0);
        chk("ld_ls_gnt", 32'(ls_gnt), 1);
        cyc(); drv(1, 32'h10, 0, 0, 0, 0);
        chk("ld_v", 32'(ls_rsp_valid), 1);
        chk("ld_d", ls_rsp_data, 32'hAABB5678);
        chk("f2_if_gnt", 32'(if_gnt), 1);
        cyc(); drv(0, 0, 0, 0, 0, 0);
        chk("f2_rsp_d", if_rsp_data, 32'hDEADBEEF);

        // Fairness: LS x4, IF, LS x4, IF
        for (int i = 0; i < 10; i++) begin
            cyc(); drv(1, 32'h10, 1, 0, 32'h30, 0);
            chk($sformatf("fair_if_gnt_%0d", i), 32'(if_gnt), (i == 4 || i == 9) ? 1 : 0);
            chk($sformatf("fair_ls_gnt_%0d", i), 32'(ls_gnt), (i == 4 || i == 9) ? 0 : 1);
        end

        // Dropping if_req mid-streak clears the count
        for (int i = 0; i < 3; i++) begin
            cyc(); drv(1, 32'h10, 1, 0, 32'h30, 0);
            chk($sformatf("drop_pre_ls_%0d", i), 32'(ls_gnt), 1);
        end
        cyc(); drv(0, 32'h10, 1, 0, 32'h30, 0);
        chk("drop_ls", 32'(ls_gnt), 1);
        for (int i = 0; i < 5; i++) begin
            cyc(); drv(1, 32'h10, 1, 0, 32'h30, 0);
            chk($sformatf("drop_post_if_%0d", i), 32'(if_gnt), (i == 4) ? 1 : 0);
        end

        // Flush kills the in-flight fetch response and blocks fetch grant
        cyc(); drv(1, 32'h10, 0, 0, 32'h30, 0);
        chk("fl_if_gnt0", 32'(if_gnt), 1);
        cyc(); flush = 1'b1; drv(1, 32'h10, 1, 0, 32'h30, 0);
        chk("fl_if_rsp_v", 32'(if_rsp_valid), 0);
        chk("fl_if_rsp_d", if_rsp_data, 0);
        chk("fl_if_gnt", 32'(if_gnt), 0);
        chk("fl_ls_gnt", 32'(ls_gnt), 1);
        cyc(); flush = 1'b0; drv(0, 0, 0, 0, 0, 0);
        chk("fl_ls_v", 32'(ls_rsp_valid), 1);
        chk("fl_ls_d", ls_rsp_data, 32'h11112222);

        // Back-to-back IF, LS load, IF (upper address bits ignored)
        cyc(); drv(1, 32'hFFFF0010, 0, 0, 0, 0);
        chk("bb_if_gnt0", 32'(if_gnt), 1);
        chk("bb_addr0", 32'(mem_addr), 4);
        cyc(); drv(0, 0, 1, 0, 32'h30, 0);
        chk("bb_ls_gnt", 32'(ls_gnt), 1);
        chk("bb_if_d0", if_rsp_data, 32'hDEADBEEF);
        cyc(); drv(1, 32'h20, 0, 0, 0, 0);
        chk("bb_if_gnt1", 32'(if_gnt), 1);
        chk("bb_ls_d", ls_rsp_data, 32'h11112222);
        chk("bb_if_v_mid", 32'(if_rsp_valid), 0);
        cyc(); drv(0, 0, 0, 0, 0, 0);
        chk("bb_if_v1", 32'(if_rsp_valid), 1);
        chk("bb_if_d1", if_rsp_data, 32'hAABB5678);
        chk("bb_ls_v_end", 32'(ls_rsp_valid), 0);

        // Reset mid-transaction: store lands, its ack is discarded
        cyc(); drv(1, 32'h10, 1, 4'hF, 32'h30, 32'h99999999);
        chk("mr_ls_gnt", 32'(ls_gnt), 1);
        cyc(); rst = 1'b1; #1;
        chk("mr_ls_v", 32'(ls_rsp_valid), 0);
        chk("mr_ls_gnt_rst", 32'(ls_gnt), 0);
        chk("mr_mem_en", 32'(mem_en), 0);
        cyc(); #1;
        chk("mr_if_gnt_rst", 32'(if_gnt), 0);
        cyc(); rst = 1'b0; drv(1, 32'h10, 1, 0, 32'h30, 0);
        chk("mr_post_ls_v", 32'(ls_rsp_valid), 0);
        chk("mr_post_if_v", 32'(if_rsp_valid), 0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin cyc(); drv(1, 32'h10, 1, 0, 32'h30, 0); end
            chk($sformatf("mr_streak_if_%0d", i), 32'(if_gnt), (i == 4) ? 1 : 0);
            if (i == 1) chk("mr_ld_d", ls_rsp_data, 32'h99999999);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
